// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, control encodings and
// the ID/EX pipeline register layout.
package riscv_pkg;

    localparam int unsigned XLEN_W = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] rs1_data;
        logic [XLEN_W-1:0] rs2_data;
        logic [XLEN_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7_5;
        aluop_t            aluop;
        logic              alusrc;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              branch;
        logic              jump;
        logic              illegal;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate from the instruction
// word and sign-extends it from instr[31] to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_W
) (
    input  logic [31:0]     i_instr,
    input  imm_fmt_t        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage with ID/EX pipeline register, load-use hazard detection,
// EX flush and downstream stall handling.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_W,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_id_valid,
    input  logic [31:0]     if_id_instr,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush_i,
    input  logic            stall_i,
    output logic            hazard_stall_o,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs1_data,
    output logic [XLEN-1:0] id_ex_rs2_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rs1,
    output logic [4:0]      id_ex_rs2,
    output logic [4:0]      id_ex_rd,
    output logic [6:0]      id_ex_opcode,
    output logic [2:0]      id_ex_funct3,
    output logic            id_ex_funct7_5,
    output logic [1:0]      id_ex_aluop,
    output logic            id_ex_alusrc,
    output logic            id_ex_regwrite,
    output logic            id_ex_memread,
    output logic            id_ex_memwrite,
    output logic            id_ex_memtoreg,
    output logic            id_ex_branch,
    output logic            id_ex_jump,
    output logic            id_ex_illegal
);

    id_ex_t          r_q;
    id_ex_t          w_d;
    id_ex_t          w_bub;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm;
    imm_fmt_t        w_fmt;
    aluop_t          w_aluop;
    logic            w_alusrc, w_regwrite, w_memread, w_memwrite, w_memtoreg;
    logic            w_branch, w_jump, w_illegal, w_funct7_5, w_no_rd;
    logic            w_uses_rs1, w_uses_rs2, w_hazard;

    assign w_opcode = if_id_instr[6:0];
    assign w_rs1    = if_id_instr[19:15];
    assign w_rs2    = if_id_instr[24:20];
    assign w_funct3 = if_id_instr[14:12];

    always_comb begin
        w_aluop    = ALU_ADD;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_illegal  = 1'b0;
        w_funct7_5 = 1'b0;
        w_no_rd    = 1'b0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        w_fmt      = IMM_NONE;
        case (w_opcode)
            OPC_R: begin
                w_aluop    = ALU_FUNCT;
                w_regwrite = 1'b1;
                w_funct7_5 = if_id_instr[30];
                w_uses_rs2 = 1'b1;
            end
            OPC_I_ALU: begin
                w_aluop    = ALU_FUNCT;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_funct7_5 = (w_funct3 == 3'b101) ? if_id_instr[30] : 1'b0;
                w_fmt      = IMM_I;
            end
            OPC_LOAD: begin
                w_alusrc   = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_fmt      = IMM_I;
            end
            OPC_STORE: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_no_rd    = 1'b1;
                w_uses_rs2 = 1'b1;
                w_fmt      = IMM_S;
            end
            OPC_BRANCH: begin
                w_aluop    = ALU_SUB;
                w_branch   = 1'b1;
                w_no_rd    = 1'b1;
                w_uses_rs2 = 1'b1;
                w_fmt      = IMM_B;
            end
            OPC_JAL: begin
                w_jump     = 1'b1;
                w_regwrite = 1'b1;
                w_uses_rs1 = 1'b0;
                w_fmt      = IMM_J;
            end
            OPC_JALR: begin
                w_jump     = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_fmt      = IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_uses_rs1 = 1'b0;
                w_fmt      = IMM_U;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_rd = w_no_rd ? 5'd0 : if_id_instr[11:7];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (if_id_instr),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // Controls are gated by if_id_valid so an empty slot can never write reg/mem.
    always_comb begin
        w_d          = '0;
        w_d.valid    = if_id_valid;
        w_d.pc       = if_id_pc;
        w_d.rs1_data = rs1_data;
        w_d.rs2_data = rs2_data;
        w_d.imm      = w_imm;
        w_d.rs1      = w_rs1;
        w_d.rs2      = w_rs2;
        w_d.rd       = w_rd;
        w_d.opcode   = w_opcode;
        w_d.funct3   = w_funct3;
        w_d.funct7_5 = w_funct7_5;
        if (if_id_valid) begin
            w_d.aluop    = w_aluop;
            w_d.alusrc   = w_alusrc;
            w_d.regwrite = w_regwrite & (w_rd != 5'd0);
            w_d.memread  = w_memread;
            w_d.memwrite = w_memwrite;
            w_d.memtoreg = w_memtoreg;
            w_d.branch   = w_branch;
            w_d.jump     = w_jump;
            w_d.illegal  = w_illegal;
        end
    end

    always_comb begin
        w_bub          = w_d;
        w_bub.valid    = 1'b0;
        w_bub.aluop    = ALU_ADD;
        w_bub.alusrc   = 1'b0;
        w_bub.regwrite = 1'b0;
        w_bub.memread  = 1'b0;
        w_bub.memwrite = 1'b0;
        w_bub.memtoreg = 1'b0;
        w_bub.branch   = 1'b0;
        w_bub.jump     = 1'b0;
        w_bub.illegal  = 1'b0;
    end

    always_comb begin
        w_hazard = r_q.valid & r_q.memread & (r_q.rd != 5'd0) & if_id_valid &
                   ((w_uses_rs1 & (w_rs1 == r_q.rd)) | (w_uses_rs2 & (w_rs2 == r_q.rd)));
    end

    assign hazard_stall_o = w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_q.pc <= RESET_PC;
        end else if (flush_i) begin
            r_q <= w_bub;
        end else if (stall_i) begin
            r_q <= r_q;
        end else if (w_hazard) begin
            r_q <= w_bub;
        end else begin
            r_q <= w_d;
        end
    end

    assign id_ex_valid    = r_q.valid;
    assign id_ex_pc       = r_q.pc;
    assign id_ex_rs1_data = r_q.rs1_data;
    assign id_ex_rs2_data = r_q.rs2_data;
    assign id_ex_imm      = r_q.imm;
    assign id_ex_rs1      = r_q.rs1;
    assign id_ex_rs2      = r_q.rs2;
    assign id_ex_rd       = r_q.rd;
    assign id_ex_opcode   = r_q.opcode;
    assign id_ex_funct3   = r_q.funct3;
    assign id_ex_funct7_5 = r_q.funct7_5;
    assign id_ex_aluop    = r_q.aluop;
    assign id_ex_alusrc   = r_q.alusrc;
    assign id_ex_regwrite = r_q.regwrite;
    assign id_ex_memread  = r_q.memread;
    assign id_ex_memwrite = r_q.memwrite;
    assign id_ex_memtoreg = r_q.memtoreg;
    assign id_ex_branch   = r_q.branch;
    assign id_ex_jump     = r_q.jump;
    assign id_ex_illegal  = r_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush_i;
    logic        stall_i;
    logic        hazard_stall_o;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7_5;
    logic [1:0]  id_ex_aluop;
    logic        id_ex_alusrc, id_ex_regwrite, id_ex_memread, id_ex_memwrite;
    logic        id_ex_memtoreg, id_ex_branch, id_ex_jump, id_ex_illegal;

    int unsigned n_chk;
    int unsigned n_err;

    id_ex_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .hazard_stall_o (hazard_stall_o),
        .id_ex_valid    (id_ex_valid),
        .id_ex_pc       (id_ex_pc),
        .id_ex_rs1_data (id_ex_rs1_data),
        .id_ex_rs2_data (id_ex_rs2_data),
        .id_ex_imm      (id_ex_imm),
        .id_ex_rs1      (id_ex_rs1),
        .id_ex_rs2      (id_ex_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_opcode   (id_ex_opcode),
        .id_ex_funct3   (id_ex_funct3),
        .id_ex_funct7_5 (id_ex_funct7_5),
        .id_ex_aluop    (id_ex_aluop),
        .id_ex_alusrc   (id_ex_alusrc),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .id_ex_memwrite (id_ex_memwrite),
        .id_ex_memtoreg (id_ex_memtoreg),
        .id_ex_branch   (id_ex_branch),
        .id_ex_jump     (id_ex_jump),
        .id_ex_illegal  (id_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_id_valid = v;
        if_id_instr = instr;
        if_id_pc    = pc;
        rs1_data    = pc ^ 32'hA5A5_0000;
        rs2_data    = pc ^ 32'h0000_5A5A;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_valid", {31'b0, id_ex_valid}, 32'd0);
        chk("rst_pc", id_ex_pc, 32'h0);
        chk("rst_regwrite", {31'b0, id_ex_regwrite}, 32'd0);
        chk("rst_hazard", {31'b0, hazard_stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h100);
        step();
        chk("add_valid", {31'b0, id_ex_valid}, 32'd1);
        chk("add_aluop", {30'b0, id_ex_aluop}, 32'd2);
        chk("add_alusrc", {31'b0, id_ex_alusrc}, 32'd0);
        chk("add_regwrite", {31'b0, id_ex_regwrite}, 32'd1);
        chk("add_rd", {27'b0, id_ex_rd}, 32'd3);
        chk("add_f7", {31'b0, id_ex_funct7_5}, 32'd0);
        chk("add_pc", id_ex_pc, 32'h100);
        chk("add_rs1d", id_ex_rs1_data, 32'hA5A5_0100);

        drive(1'b1, 32'h402081B3, 32'h104);
        step();
        chk("sub_f7", {31'b0, id_ex_funct7_5}, 32'd1);
        chk("sub_aluop", {30'b0, id_ex_aluop}, 32'd2);

        drive(1'b1, 32'hFFF00293, 32'h108);
        step();
        chk("addi_imm", id_ex_imm, 32'hFFFF_FFFF);
        chk("addi_alusrc", {31'b0, id_ex_alusrc}, 32'd1);
        chk("addi_f7", {31'b0, id_ex_funct7_5}, 32'd0);
        chk("addi_rd", {27'b0, id_ex_rd}, 32'd5);

        drive(1'b1, 32'h4032D293, 32'h10C);
        step();
        chk("srai_f7", {31'b0, id_ex_funct7_5}, 32'd1);
        chk("srai_imm", id_ex_imm, 32'h0000_0403);
        chk("srai_f3", {29'b0, id_ex_funct3}, 32'd5);

        // lw x6,0(x1) followed by dependent add x7,x6,x2
        drive(1'b1, 32'h0000A303, 32'h110);
        step();
        chk("lw_memread", {31'b0, id_ex_memread}, 32'd1);
        chk("lw_memtoreg", {31'b0, id_ex_memtoreg}, 32'd1);
        chk("lw_regwrite", {31'b0, id_ex_regwrite}, 32'd1);
        chk("lw_rd", {27'b0, id_ex_rd}, 32'd6);
        drive(1'b1, 32'h002303B3, 32'h114);
        #1;
        chk("lu_hazard", {31'b0, hazard_stall_o}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'b0, id_ex_valid}, 32'd0);
        chk("lu_bubble_regwrite", {31'b0, id_ex_regwrite}, 32'd0);
        chk("lu_bubble_memread", {31'b0, id_ex_memread}, 32'd0);
        chk("lu_hazard_gone", {31'b0, hazard_stall_o}, 32'd0);
        step();
        chk("lu_add_valid", {31'b0, id_ex_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, id_ex_rd}, 32'd7);
        chk("lu_add_pc", id_ex_pc, 32'h114);

        // lw x0 must never stall a consumer of x0
        drive(1'b1, 32'h0000A003, 32'h118);
        step();
        chk("lw0_memread", {31'b0, id_ex_memread}, 32'd1);
        chk("lw0_regwrite", {31'b0, id_ex_regwrite}, 32'd0);
        drive(1'b1, 32'h002003B3, 32'h11C);
        #1;
        chk("lw0_hazard", {31'b0, hazard_stall_o}, 32'd0);
        step();
        chk("lw0_next_valid", {31'b0, id_ex_valid}, 32'd1);

        // sw x2,4(x1)
        drive(1'b1, 32'h0020A223, 32'h120);
        step();
        chk("sw_memwrite", {31'b0, id_ex_memwrite}, 32'd1);
        chk("sw_rd", {27'b0, id_ex_rd}, 32'd0);
        chk("sw_imm", id_ex_imm, 32'h4);
        chk("sw_regwrite", {31'b0, id_ex_regwrite}, 32'd0);

        // jal x1,8
        drive(1'b1, 32'h008000EF, 32'h124);
        step();
        chk("jal_jump", {31'b0, id_ex_jump}, 32'd1);
        chk("jal_regwrite", {31'b0, id_ex_regwrite}, 32'd1);
        chk("jal_imm", id_ex_imm, 32'h8);

        // lui x4,0x12345
        drive(1'b1, 32'h12345237, 32'h128);
        step();
        chk("lui_imm", id_ex_imm, 32'h1234_5000);
        chk("lui_alusrc", {31'b0, id_ex_alusrc}, 32'd1);

        // beq x1,x2,-8
        drive(1'b1, 32'hFE208CE3, 32'h12C);
        step();
        chk("beq_aluop", {30'b0, id_ex_aluop}, 32'd1);
        chk("beq_branch", {31'b0, id_ex_branch}, 32'd1);
        chk("beq_rd", {27'b0, id_ex_rd}, 32'd0);
        chk("beq_imm", id_ex_imm, 32'hFFFF_FFF8);
        chk("beq_regwrite", {31'b0, id_ex_regwrite}, 32'd0);

        drive(1'b1, 32'h002081B3, 32'h130);
        flush_i = 1'b1;
        stall_i = 1'b1;
        step();
        chk("flushstall_valid", {31'b0, id_ex_valid}, 32'd0);
        chk("flushstall_branch", {31'b0, id_ex_branch}, 32'd0);
        chk("flushstall_regwrite", {31'b0, id_ex_regwrite}, 32'd0);
        flush_i = 1'b0;
        stall_i = 1'b0;

        // Downstream stall holds contents across changing inputs
        drive(1'b1, 32'h002081B3, 32'h200);
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000A303 + 32'(i << 7), 32'h300 + 32'(i * 4));
            step();
            chk("stall_valid", {31'b0, id_ex_valid}, 32'd1);
            chk("stall_pc", id_ex_pc, 32'h200);
            chk("stall_rd", {27'b0, id_ex_rd}, 32'd3);
            chk("stall_memread", {31'b0, id_ex_memread}, 32'd0);
        end
        stall_i = 1'b0;

        drive(1'b1, 32'h0000007F, 32'h204);
        step();
        chk("ill_valid", {31'b0, id_ex_valid}, 32'd1);
        chk("ill_illegal", {31'b0, id_ex_illegal}, 32'd1);
        chk("ill_regwrite", {31'b0, id_ex_regwrite}, 32'd0);

        // Invalid slot loads as a bubble
        drive(1'b0, 32'h002081B3, 32'h208);
        step();
        chk("inv_valid", {31'b0, id_ex_valid}, 32'd0);
        chk("inv_regwrite", {31'b0, id_ex_regwrite}, 32'd0);

        drive(1'b1, 32'h0000A303, 32'h20C);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, id_ex_valid}, 32'd0);
        chk("mid_rst_memread", {31'b0, id_ex_memread}, 32'd0);
        chk("mid_rst_pc", id_ex_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h210);
        step();
        chk("post_rst_valid", {31'b0, id_ex_valid}, 32'd1);
        chk("post_rst_pc", id_ex_pc, 32'h210);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
